// File: rtl/vga_timing_gen.sv
// Pixel-rate VGA raster timing generator: h/v position counters advanced by a
// pix_en clock enable, with registered sync, blanking and line/frame strobes.
module vga_timing_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_START = 10'(H_VISIBLE);
  localparam logic [9:0] H_SY_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_BP_START = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_START = 10'(V_VISIBLE);
  localparam logic [9:0] V_SY_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_BP_START = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {VISIBLE, FRONT, SYNC, BACK} phase_t;

  // Reset asserts asynchronously but releases two clk edges after reset_n rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [9:0] h, v, h_next, v_next;
  logic       h_wrap, v_wrap;
  phase_t     h_state, v_state, h_state_next, v_state_next;

  // Each region is entered at its first coordinate; every region is assumed non-empty.
  function automatic phase_t next_phase(input phase_t cur, input logic [9:0] pos,
                                        input logic [9:0] fp, input logic [9:0] sy,
                                        input logic [9:0] bp);
    next_phase = cur;
    case (cur)
      VISIBLE: if (pos == fp)    next_phase = FRONT;
      FRONT:   if (pos == sy)    next_phase = SYNC;
      SYNC:    if (pos == bp)    next_phase = BACK;
      BACK:    if (pos == 10'd0) next_phase = VISIBLE;
      default:                   next_phase = BACK;
    endcase
  endfunction

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    h_wrap       = (h == H_LAST);
    v_wrap       = (v == V_LAST);
    h_next       = h_wrap ? 10'd0 : h + 10'd1;
    v_next       = h_wrap ? (v_wrap ? 10'd0 : v + 10'd1) : v;
    h_state_next = h_state;
    v_state_next = v_state;
    if (pix_en) begin
      h_state_next = next_phase(h_state, h_next, H_FP_START, H_SY_START, H_BP_START);
      if (h_wrap)
        v_state_next = next_phase(v_state, v_next, V_FP_START, V_SY_START, V_BP_START);
    end
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h           <= H_LAST;
      v           <= V_LAST;
      h_state     <= BACK;
      v_state     <= BACK;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        h           <= h_next;
        v           <= v_next;
        h_state     <= h_state_next;
        v_state     <= v_state_next;
        hsync       <= (h_state_next == SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync       <= (v_state_next == SYNC) ? SYNC_POL : ~SYNC_POL;
        video_on    <= (h_state_next == VISIBLE) && (v_state_next == VISIBLE);
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

  assign pixel_x = h;
  assign pixel_y = v;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 (both sync polarities)
// plus a miniature raster so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_en = 1'b0;

  logic       a_hs, a_vs, a_von, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_hs, b_vs, b_von, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_hs, c_vs, c_von, c_ls, c_fs;
  logic [9:0] c_x, c_y;

  int total = 0;
  int bad   = 0;

  // Reference positions for the default raster (a/b) and the mini raster (c).
  int   mh_a, mv_a, mh_c, mv_c;
  logic ls_a, fs_a, ls_c, fs_c;

  always #10 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .pixel_x(a_x), .pixel_y(a_y),
    .line_start(a_ls), .frame_start(a_fs));

  vga_timing_gen #(.SYNC_POL(1'b1)) u_b (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .pixel_x(b_x), .pixel_y(b_y),
    .line_start(b_ls), .frame_start(b_fs));

  // Mini raster: H = 8+2+3+2 = 15, V = 4+1+2+2 = 9, frame = 135 pixels.
  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)) u_c (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(c_hs), .vsync(c_vs), .video_on(c_von), .pixel_x(c_x), .pixel_y(c_y),
    .line_start(c_ls), .frame_start(c_fs));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_sync(input int pos, input int lo, input int w, input logic pol);
    return (pos >= lo && pos < lo + w) ? pol : ~pol;
  endfunction

  task automatic model_reset();
    mh_a = 799; mv_a = 524; mh_c = 14; mv_c = 8;
    ls_a = 0; fs_a = 0; ls_c = 0; fs_c = 0;
  endtask

  task automatic model_clk(input logic en);
    if (!reset_n) begin
      model_reset();
    end else begin
      ls_a = 0; fs_a = 0; ls_c = 0; fs_c = 0;
      if (en) begin
        ls_a = (mh_a == 799);
        fs_a = ls_a && (mv_a == 524);
        mh_a = ls_a ? 0 : mh_a + 1;
        if (ls_a) mv_a = (mv_a == 524) ? 0 : mv_a + 1;
        ls_c = (mh_c == 14);
        fs_c = ls_c && (mv_c == 8);
        mh_c = ls_c ? 0 : mh_c + 1;
        if (ls_c) mv_c = (mv_c == 8) ? 0 : mv_c + 1;
      end
    end
  endtask

  task automatic check_all();
    check("a_x",     a_x,   mh_a);
    check("a_y",     a_y,   mv_a);
    check("a_hsync", a_hs,  exp_sync(mh_a, 656, 96, 1'b0));
    check("a_vsync", a_vs,  exp_sync(mv_a, 490, 2, 1'b0));
    check("a_video", a_von, (mh_a < 640) && (mv_a < 480));
    check("a_line",  a_ls,  ls_a);
    check("a_frame", a_fs,  fs_a);
    check("b_x",     b_x,   mh_a);
    check("b_y",     b_y,   mv_a);
    check("b_hsync", b_hs,  exp_sync(mh_a, 656, 96, 1'b1));
    check("b_vsync", b_vs,  exp_sync(mv_a, 490, 2, 1'b1));
    check("b_video", b_von, (mh_a < 640) && (mv_a < 480));
    check("b_frame", b_fs,  fs_a);
    check("c_x",     c_x,   mh_c);
    check("c_y",     c_y,   mv_c);
    check("c_hsync", c_hs,  exp_sync(mh_c, 10, 3, 1'b0));
    check("c_vsync", c_vs,  exp_sync(mv_c, 5, 2, 1'b0));
    check("c_video", c_von, (mh_c < 8) && (mv_c < 4));
    check("c_line",  c_ls,  ls_c);
    check("c_frame", c_fs,  fs_c);
  endtask

  // Drive pix_en for one clk, then sample on the following falling edge.
  task automatic step(input logic en);
    pix_en = en;
    @(posedge clk);
    model_clk(en);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int hs_low, von_fall, vs_low, fs_cnt, first_fs, period, cyc, found;
    int c_hs_pix, c_vs_pix;

    model_reset();
    @(negedge clk);

    // Reset held with pix_en toggling.
    for (int i = 0; i < 6; i++) step(i[0]);
    check("rst_x", a_x, 10'd799);
    check("rst_y", a_y, 10'd524);
    check("rst_hsync", a_hs, 1'b1);
    check("rst_vsync", a_vs, 1'b1);
    check("rst_video", a_von, 1'b0);
    check("rst_strobes", {a_ls, a_fs}, 2'b00);

    // Release; wait out the reset synchronizer, then the first pixel.
    reset_n = 1'b1;
    repeat (3) step(1'b0);
    check("idle_x", a_x, 10'd799);
    step(1'b1);
    check("first_xy", {a_y, a_x}, 20'd0);
    check("first_video", a_von, 1'b1);
    check("first_strobes", {a_ls, a_fs}, 2'b11);
    check("first_c_strobes", {c_ls, c_fs}, 2'b11);
    step(1'b0);
    check("first_strobes_end", {a_ls, a_fs}, 2'b00);

    // Rest of line 0 with pix_en every second clk.
    hs_low = 0; von_fall = -1;
    for (int i = 1; i < 800; i++) begin
      step(1'b1);
      if (a_hs == 1'b0) hs_low++;
      if (!a_von && von_fall < 0) von_fall = int'(a_x);
      step(1'b0);
      if (a_hs == 1'b0) hs_low++;
    end
    check("hsync_low_clks", hs_low, 192);
    check("video_fall_x", von_fall, 640);
    step(1'b1);
    check("wrap_xy", {a_y, a_x}, {10'd1, 10'd0});
    check("wrap_strobes", {a_ls, a_fs}, 2'b10);

    // Continuous pix_en for exactly two mini frames.
    vs_low = 0; fs_cnt = 0; first_fs = -1; period = -1;
    for (cyc = 0; cyc < 270; cyc++) begin
      step(1'b1);
      if (c_vs == 1'b0) vs_low++;
      if (c_fs) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = cyc;
        else if (period < 0) period = cyc - first_fs;
      end
    end
    check("cont_vsync_low_clks", vs_low, 60);
    check("cont_frame_starts", fs_cnt, 2);
    check("cont_frame_period", period, 135);

    // Random 0..5 clk gaps between strobes, again two mini frames of pixels.
    c_hs_pix = 0; c_vs_pix = 0; fs_cnt = 0;
    for (int i = 0; i < 270; i++) begin
      repeat ($urandom_range(0, 5)) step(1'b0);
      step(1'b1);
      if (c_hs == 1'b0) c_hs_pix++;
      if (c_vs == 1'b0) c_vs_pix++;
      if (c_fs) fs_cnt++;
    end
    check("gap_hsync_pixels", c_hs_pix, 54);
    check("gap_vsync_pixels", c_vs_pix, 60);
    check("gap_frame_starts", fs_cnt, 2);

    // Mid-frame reset at pixel_x = 300.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (mh_a == 300) found = 1;
      else step(1'b1);
    end
    check("reach_x300", found, 1);
    check("pre_reset_x", a_x, 10'd300);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async_rst_x", a_x, 10'd799);
    check("async_rst_b_hsync", b_hs, 1'b0);
    for (int i = 0; i < 4; i++) step(i[0]);
    reset_n = 1'b1;
    repeat (3) step(1'b0);
    step(1'b1);
    check("resume_xy", {a_y, a_x}, 20'd0);
    check("resume_strobes", {a_ls, a_fs}, 2'b11);
    check("resume_b_xy", {b_y, b_x}, 20'd0);
    check("resume_b_sync", {b_hs, b_vs}, 2'b00);
    step(1'b0);
    check("resume_strobes_end", {a_fs, c_fs}, 2'b00);
    repeat (5) step(1'b1);
    check("resume_x5", a_x, 10'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
